// File: rtl/output_line_buffer.sv
// First-word-fall-through FIFO buffering a CPU output line for a consumer.
// Optional saturating drop counter enabled by `OUTPUT_LINE_DROP_COUNT_EN.
module output_line_buffer #(
   parameter int BITS  = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [BITS-1:0]          wr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BITS-1:0]          out_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [BITS-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   cnt;
   logic            ovf;

   logic pop;
   logic push;
   logic drop;

   // Outputs come only from registered state (count compare, read mux).
   assign out_valid = (cnt != '0);
   assign full      = (cnt == FULL_CNT);
   assign count     = cnt;
   assign overflow  = ovf;
   assign out_data  = mem[rptr];

   assign pop  = out_valid & out_ready;
   assign push = wr_en & (~full | pop);
   assign drop = wr_en & full & ~pop;

   always_ff @(posedge clk) begin
      if (push && rst)
         mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (drop)
            ovf <= 1'b1;
      end
   end

`ifdef OUTPUT_LINE_DROP_COUNT_EN
   logic [7:0] drops;

   always_ff @(posedge clk) begin
      if (!rst)
         drops <= '0;
      else if (drop && drops != 8'hFF)
         drops <= drops + 8'd1;
   end

   assign drop_count = drops;
`else
   assign drop_count = 8'd0;
`endif

endmodule
